data_mem_responder: RTL
=======================

# data_mem_responder

Bus responder (data memory) for the RV32I CPU's load/store bus: accepts one request at a time from the CPU datapath's bus initiator port (busAddr/busWData/busRData), performs byte/halfword/word reads and writes on a word-organised RAM, and returns read data with load sign/zero extension applied. A 3-state FSM produces a fixed two-cycle request-to-ready latency, so the multi-cycle CPU's memory state waits on busReady instead of relying on combinational reads.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; byte address space is 0 .. 4*DEPTH_WORDS-1
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- busReq  input  1  request valid; initiator holds it and all request fields stable until busReady
- busWe  input  1  1 = store, 0 = load
- busAddr  input  32  byte address
- busSize  input  3  instruction func3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- busWData  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- busReady  output  1  one-cycle pulse: transaction complete, busRData/busErr valid
- busRData  output  32  load result, extended per busSize; 0 for stores and errors
- busErr  output  1  request rejected (misaligned, out of range, illegal size); valid with busReady

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: busReady=0. If busReq=1 at a rising edge, latch busWe, busAddr, busSize, busWData; go to ACCESS. Otherwise stay.
- ACCESS: decode latched request; compute err; on the exiting edge: if store and !err, write selected bytes; if load, register extended read data (0 if err) into busRData; register err into busErr; go to DONE.
- DONE: busReady=1 for exactly this cycle; go to IDLE unconditionally.
- Error conditions (any one sets err): busSize not in {000,001,010,100,101}; store with busSize in {100,101}; H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
- Byte lanes: word index = addr[31:2]; B lane = addr[1:0]; H lanes = addr[1] ? [31:16] : [15:0].
- Store: SB writes busWData[7:0] into lane, SH writes busWData[15:0] into half, SW writes all 4 bytes; unselected bytes unchanged.
- Load: LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend; LW returns full word.
- Errored store: memory unchanged. Errored load: busRData=0.
- busRData and busErr hold their registered values outside DONE; initiator samples them only when busReady=1.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, busReady=0, busRData=0, busErr=0 immediately; no memory write occurs.
- Latency: busReq sampled at edge N -> ACCESS in cycle N..N+1 -> busReady=1 in cycle after edge N+1; fixed 2 cycles, no back-pressure.
- Back-to-back: busReq still high in the IDLE cycle after DONE starts a new transaction; max throughput one transaction per 3 cycles.
- Request fields are latched at the IDLE->ACCESS edge; changes after that have no effect on the current transaction.
- Reset asserted during ACCESS: the pending store is not committed; FSM returns to IDLE.
- Read-after-write: a load issued after a store's busReady observes the stored data.

## Structure
- Shared package bus_pkg: state enum (IDLE, ACCESS, DONE) and busSize codes (SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU), reused by the CPU control unit for load/store func3.
- One sub-module data_ram_bytes: synchronous-write RAM of DEPTH_WORDS x 32 with 4-bit byte enable and asynchronous word read; FSM, lane select, extension and error logic stay in the top module.

## Test plan
- Reset: hold reset_n=0 with busReq=1 -> busReady=0, busRData=0, busErr=0; no transaction starts until reset_n=1.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> busReady 2 cycles after each request, busErr=0, busRData=0xDEADBEEF.
- SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SH addr 0x12 data 0x1234, then LH 0x12 -> 0x00001234; LW 0x10 -> 0x123480EF.
- Errors: LW 0x13, SH 0x11, SB 0x400 (DEPTH_WORDS=256), busSize=011 -> each busErr=1, busRData=0; LW 0x10 afterwards still 0x123480EF.
- Back-to-back busReq held high for 3 loads -> busReady pulses exactly every 3rd cycle; reset_n pulsed low during ACCESS of SW 0x20 -> later LW 0x20 returns prior contents.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared load/store bus types: FSM states and busSize (func3) codes
package bus_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_e;

  // busSize codes, identical to the load/store func3 field
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU load/store bus between initiator and data memory
interface data_mem_responder_if;

  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [2:0]  busSize;
  logic [31:0] busWData;
  logic        busReady;
  logic [31:0] busRData;
  logic        busErr;

  // CPU datapath side
  modport master (
    output busReq, busWe, busAddr, busSize, busWData,
    input  busReady, busRData, busErr
  );

  // Memory responder side
  modport slave (
    input  busReq, busWe, busAddr, busSize, busWData,
    output busReady, busRData, busErr
  );

endinterface

// File: rtl/data_ram_bytes.sv
// rtl/data_ram_bytes.sv - word RAM with byte-enable synchronous write and asynchronous read
module data_ram_bytes #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory bus responder with fixed two-cycle latency
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  data_mem_responder_if.slave bus
);
  import bus_pkg::*;

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  bus_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        err;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] load_val;
  logic [31:0] ram_rdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        ram_we;

  // Decode the latched request: error, byte enables, lane-replicated store data, extended load
  always_comb begin
    err      = 1'b0;
    be       = 4'b0000;
    wlanes   = wdata_q;
    load_val = ram_rdata;
    case (addr_q[1:0])
      2'd0:    sel_byte = ram_rdata[7:0];
      2'd1:    sel_byte = ram_rdata[15:8];
      2'd2:    sel_byte = ram_rdata[23:16];
      default: sel_byte = ram_rdata[31:24];
    endcase
    sel_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      SIZE_B: begin
        be       = 4'b0001 << addr_q[1:0];
        wlanes   = {4{wdata_q[7:0]}};
        load_val = {{24{sel_byte[7]}}, sel_byte};
      end
      SIZE_BU: begin
        err      = we_q;
        load_val = {24'b0, sel_byte};
      end
      SIZE_H: begin
        err      = addr_q[0];
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata_q[15:0]}};
        load_val = {{16{sel_half[15]}}, sel_half};
      end
      SIZE_HU: begin
        err      = we_q | addr_q[0];
        load_val = {16'b0, sel_half};
      end
      SIZE_W: begin
        err      = (addr_q[1:0] != 2'b00);
        be       = 4'b1111;
      end
      default: err = 1'b1;
    endcase
    if (addr_q[31:2] >= DEPTH_LIM) err = 1'b1;
  end

  // Commit only from ACCESS; reset_n gating keeps an interrupted store from landing
  assign ram_we = (state_q == ACCESS) && we_q && !err && reset_n;

  data_ram_bytes #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .addr  (addr_q[AW+1:2]),
    .wdata (wlanes),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: accept in IDLE, then fixed ACCESS -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.busReq) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch at acceptance and result capture at the end of ACCESS
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.busReq) begin
      we_d    = bus.busWe;
      addr_d  = bus.busAddr;
      size_d  = bus.busSize;
      wdata_d = bus.busWData;
    end
    if (state_q == ACCESS) begin
      err_d   = err;
      rdata_d = (we_q || err) ? 32'b0 : load_val;
    end
  end

  // Request and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      size_q  <= 3'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs: ready pulses in DONE, result registers hold otherwise
  always_comb begin
    bus.busReady = (state_q == DONE);
    bus.busRData = rdata_q;
    bus.busErr   = err_q;
  end

endmodule
